// File: rtl/slc3_instr_decoder.sv
// slc3_instr_decoder: registered decode stage for SLC-3 instruction words.
// Accepts a 16-bit word over valid/ready, and emits a decoded record with
// opcode, register fields, nzp, extended immediate and class flags. An
// output register plus a one-word skid register give two entries of
// buffering, so a full 1-per-cycle stream survives backpressure with
// in_ready driven from a flop.
//
// Optional feature: define SLC3_MUL_DECODE_EN to decode opcode 1111 as MUL.
//
// Ports:
//   Clk, Reset        clock, synchronous active-high reset
//   in_valid/in_ready input handshake, instr_in raw instruction word
//   out_valid/out_ready output handshake for the decoded record
//   out_op, out_dr, out_sr1, out_sr2, out_nzp, out_use_imm, out_imm,
//   out_writes_reg, out_is_mem, out_is_ctrl, out_illegal   decoded record
//   decode_count      records consumed (wraps)
//   illegal_count     illegal records consumed (saturates)
module slc3_instr_decoder #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned ILL_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       instr_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_op,
  output logic [2:0]        out_dr,
  output logic [2:0]        out_sr1,
  output logic [2:0]        out_sr2,
  output logic [2:0]        out_nzp,
  output logic              out_use_imm,
  output logic [15:0]       out_imm,
  output logic              out_writes_reg,
  output logic              out_is_mem,
  output logic              out_is_ctrl,
  output logic              out_illegal,
  output logic [CNT_W-1:0]  decode_count,
  output logic [ILL_W-1:0]  illegal_count
);

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned REG_W   = 3;

  localparam logic [OP_W-1:0] OP_BR  = 4'b0000;
  localparam logic [OP_W-1:0] OP_ADD = 4'b0001;
  localparam logic [OP_W-1:0] OP_JSR = 4'b0100;
  localparam logic [OP_W-1:0] OP_AND = 4'b0101;
  localparam logic [OP_W-1:0] OP_LDR = 4'b0110;
  localparam logic [OP_W-1:0] OP_STR = 4'b0111;
  localparam logic [OP_W-1:0] OP_NOT = 4'b1001;
  localparam logic [OP_W-1:0] OP_JMP = 4'b1100;
  localparam logic [OP_W-1:0] OP_PSE = 4'b1101;
`ifdef SLC3_MUL_DECODE_EN
  localparam logic [OP_W-1:0] OP_MUL = 4'b1111;
`endif

  typedef struct packed {
    logic [OP_W-1:0]    op;
    logic [REG_W-1:0]   dr;
    logic [REG_W-1:0]   sr1;
    logic [REG_W-1:0]   sr2;
    logic [REG_W-1:0]   nzp;
    logic               use_imm;
    logic [INSTR_W-1:0] imm;
    logic               writes_reg;
    logic               is_mem;
    logic               is_ctrl;
    logic               illegal;
  } rec_t;

  logic               in_ready_q,   in_ready_d;
  logic               out_valid_q,  out_valid_d;
  logic               skid_full_q,  skid_full_d;
  logic [INSTR_W-1:0] skid_word_q,  skid_word_d;
  rec_t               rec_q,        rec_d;
  logic [CNT_W-1:0]   dec_cnt_q,    dec_cnt_d;
  logic [ILL_W-1:0]   ill_cnt_q,    ill_cnt_d;

  logic [INSTR_W-1:0] sel_word;
  rec_t               dec;
  logic               out_fire;
  logic               in_fire;
  logic               out_free;

  // The word headed for the output register: skid first, preserving order.
  assign sel_word = skid_full_q ? skid_word_q : instr_in;

  // Combinational decode of the selected word.
  always_comb begin
    dec            = '0;
    dec.op         = sel_word[15:12];
    dec.dr         = sel_word[11:9];
    dec.sr1        = sel_word[8:6];
    dec.sr2        = sel_word[2:0];
    case (sel_word[15:12])
      OP_ADD, OP_AND: begin
        dec.writes_reg = 1'b1;
        dec.use_imm    = sel_word[5];
        dec.imm        = sel_word[5] ? {{11{sel_word[4]}}, sel_word[4:0]} : '0;
      end
`ifdef SLC3_MUL_DECODE_EN
      OP_MUL: begin
        dec.writes_reg = 1'b1;
        dec.use_imm    = sel_word[5];
        dec.imm        = sel_word[5] ? {{11{sel_word[4]}}, sel_word[4:0]} : '0;
      end
`endif
      OP_NOT: dec.writes_reg = 1'b1;
      OP_BR: begin
        dec.nzp     = sel_word[11:9];
        dec.imm     = {{7{sel_word[8]}}, sel_word[8:0]};
        dec.is_ctrl = 1'b1;
      end
      OP_JMP: dec.is_ctrl = 1'b1;
      OP_JSR: begin
        // JSRR form (bit 11 clear) is not supported.
        if (sel_word[11]) begin
          dec.imm        = {{5{sel_word[10]}}, sel_word[10:0]};
          dec.is_ctrl    = 1'b1;
          dec.writes_reg = 1'b1;
          dec.dr         = 3'b111;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_LDR: begin
        dec.imm        = {{10{sel_word[5]}}, sel_word[5:0]};
        dec.is_mem     = 1'b1;
        dec.writes_reg = 1'b1;
      end
      OP_STR: begin
        dec.imm    = {{10{sel_word[5]}}, sel_word[5:0]};
        dec.is_mem = 1'b1;
      end
      OP_PSE: begin
        dec.imm     = {4'b0000, sel_word[11:0]};
        dec.is_ctrl = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  // Output register / skid register control and statistics.
  always_comb begin
    out_fire    = out_valid_q & out_ready;
    in_fire     = in_valid & in_ready_q;
    out_free    = ~out_valid_q | out_ready;
    out_valid_d = out_valid_q;
    skid_full_d = skid_full_q;
    skid_word_d = skid_word_q;
    rec_d       = rec_q;
    dec_cnt_d   = dec_cnt_q;
    ill_cnt_d   = ill_cnt_q;

    if (skid_full_q) begin
      if (out_fire) begin
        out_valid_d = 1'b1;
        rec_d       = dec;
        skid_full_d = 1'b0;
      end
    end else if (in_fire) begin
      if (out_free) begin
        out_valid_d = 1'b1;
        rec_d       = dec;
      end else begin
        skid_full_d = 1'b1;
        skid_word_d = instr_in;
      end
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end

    in_ready_d = ~skid_full_d;

    if (out_fire) begin
      dec_cnt_d = dec_cnt_q + CNT_W'(1);
      if (rec_q.illegal && (ill_cnt_q != {ILL_W{1'b1}})) begin
        ill_cnt_d = ill_cnt_q + ILL_W'(1);
      end
    end
  end

  // State registers; reset discards any buffered words.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      skid_full_q <= 1'b0;
      skid_word_q <= '0;
      rec_q       <= '0;
      dec_cnt_q   <= '0;
      ill_cnt_q   <= '0;
    end else begin
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      skid_full_q <= skid_full_d;
      skid_word_q <= skid_word_d;
      rec_q       <= rec_d;
      dec_cnt_q   <= dec_cnt_d;
      ill_cnt_q   <= ill_cnt_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = out_valid_q;
  assign out_op         = rec_q.op;
  assign out_dr         = rec_q.dr;
  assign out_sr1        = rec_q.sr1;
  assign out_sr2        = rec_q.sr2;
  assign out_nzp        = rec_q.nzp;
  assign out_use_imm    = rec_q.use_imm;
  assign out_imm        = rec_q.imm;
  assign out_writes_reg = rec_q.writes_reg;
  assign out_is_mem     = rec_q.is_mem;
  assign out_is_ctrl    = rec_q.is_ctrl;
  assign out_illegal    = rec_q.illegal;
  assign decode_count   = dec_cnt_q;
  assign illegal_count  = ill_cnt_q;

endmodule
